// File: rtl/addsub_pkg.sv
// Shared types and constant table for the add/subtract-constant datapath.
// Provides op encoding, constant selector type and the constant lookup.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef logic [1:0] const_sel_t;

  localparam int CONST_TABLE [4] = '{1, 3, 5, 7};

  // Odd constant for a selector, masked to the datapath width.
  function automatic logic [31:0] const_value(
    input const_sel_t sel,
    input int         width
  );
    logic [31:0] v;
    v = 32'(CONST_TABLE[sel]);
    if (width < 32) v = v & ((32'd1 << width) - 32'd1);
    return v;
  endfunction

endpackage

// File: rtl/full_adder_n_bit.sv
// Parametrised ripple-carry adder, successor of the 8-bit full adder.
// Ports: a, b (operands), c_in (carry in), sum, c_out (carry out).
module full_adder_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[WIDTH];

endmodule

// File: rtl/addsub_const_pipe.sv
// Adds/subtracts an odd constant to the input word or accumulator, with a
// registered valid/ready output, carry/borrow, overflow and saturation.
// Ports: clk, reset (async high), in_valid/in_ready/in_data, const_sel, op,
// acc_mode, acc_clear, out_valid/out_ready, out_data, out_carry, out_ovf.
module addsub_const_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       const_sel,
  input  logic             op,
  input  logic             acc_mode,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] accQ;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] kVal;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] rawSum;
  logic [WIDTH-1:0] finalData;
  logic             subOp;
  logic             cOut;
  logic             ovf;
  logic             accept;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign subOp = (op_e'(op) == OP_SUB);
  assign kVal  = WIDTH'(const_value(const_sel, WIDTH));
  assign opA   = acc_mode ? accQ : in_data;
  // Subtraction is A + ~K + 1 through the same adder.
  assign opB   = subOp ? ~kVal : kVal;

  full_adder_n_bit #(
    .WIDTH(WIDTH)
  ) uAdder (
    .a    (opA),
    .b    (opB),
    .c_in (subOp),
    .sum  (rawSum),
    .c_out(cOut)
  );

  assign ovf = (opA[MSB] == opB[MSB]) & (rawSum[MSB] != opA[MSB]);

  always_comb begin
    finalData = rawSum;
    if ((SATURATE != 0) && ovf) begin
      finalData = opA[MSB] ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= finalData;
      out_carry <= subOp ? ~cOut : cOut;
      out_ovf   <= ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear beats the update; the result itself already used the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accQ <= '0;
    end else if (acc_clear) begin
      accQ <= '0;
    end else if (accept) begin
      accQ <= finalData;
    end
  end

endmodule
